// File: rtl/peripheral_ram_bridge.sv
// peripheral_ram_bridge: valid/ready request front end for the peripheral
// single-port RAM. Reads are captured from ram_dout one cycle after issue.
// Every transaction is returned through a small in-order response FIFO.
// Optional: define PERIPHERAL_RAM_BRIDGE_STATS_EN to add saturating
// read/write/error request counters (stat_rd, stat_wr, stat_err).
module peripheral_ram_bridge #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned MEMORY_SIZE = 256,
  parameter int unsigned RSP_DEPTH   = 3
) (
  input  logic          mclk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [1:0]    req_be,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_we,
  output logic          rsp_err,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_cen,
  output logic [1:0]    ram_wen
`ifdef PERIPHERAL_RAM_BRIDGE_STATS_EN
  ,
  output logic [15:0]   stat_rd,
  output logic [15:0]   stat_wr,
  output logic [15:0]   stat_err
`endif
);

  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam logic [AW:0]   LIMIT   = (AW+1)'(MEMORY_SIZE / 2);
  localparam logic [PW-1:0] LAST    = PW'(RSP_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(RSP_DEPTH);

  logic          acc;
  logic          inr;
  logic          push;
  logic          pop;
  logic          p_valid;
  logic          p_we;
  logic          p_err;
  logic [DW-1:0] cap_rdata;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [DW-1:0] f_rdata [RSP_DEPTH];
  logic          f_we    [RSP_DEPTH];
  logic          f_err   [RSP_DEPTH];

  // Request acceptance and RAM pin drive, all combinational from the request port
  always_comb begin
    req_ready = ({1'b0, fifo_count} + (CW+1)'(p_valid)) < DEPTH_W;
    acc       = req_valid & req_ready;
    inr       = {1'b0, req_addr} < LIMIT;
    ram_addr  = req_addr;
    ram_din   = req_wdata;
    ram_cen   = ~(acc & inr & (~req_we | (req_be != 2'b00)));
    ram_wen   = req_we ? ~req_be : 2'b11;
  end

  // In-flight stage: remembers what was issued so dout can be captured next cycle
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      p_valid <= 1'b0;
      p_we    <= 1'b0;
      p_err   <= 1'b0;
    end else begin
      p_valid <= acc;
      p_we    <= req_we;
      p_err   <= ~inr;
    end
  end

  // Push/pop decode; read data only comes from the RAM for in-range reads
  always_comb begin
    push      = p_valid;
    pop       = rsp_valid & rsp_ready;
    cap_rdata = (~p_we & ~p_err) ? ram_dout : '0;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because outputs are gated by rsp_valid
  always_ff @(posedge mclk) begin
    if (push) begin
      f_rdata[wr_ptr] <= cap_rdata;
      f_we[wr_ptr]    <= p_we;
      f_err[wr_ptr]   <= p_err;
    end
  end

  // Response port driven from the FIFO head
  always_comb begin
    rsp_valid = (fifo_count != '0);
    rsp_rdata = rsp_valid ? f_rdata[rd_ptr] : '0;
    rsp_we    = rsp_valid ? f_we[rd_ptr]    : 1'b0;
    rsp_err   = rsp_valid ? f_err[rd_ptr]   : 1'b0;
  end

`ifdef PERIPHERAL_RAM_BRIDGE_STATS_EN
  // Saturating counters bumped on the edge a request is accepted
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      stat_rd  <= '0;
      stat_wr  <= '0;
      stat_err <= '0;
    end else if (acc) begin
      if (!inr) begin
        if (stat_err != '1) stat_err <= stat_err + 16'd1;
      end else if (req_we) begin
        if (stat_wr != '1) stat_wr <= stat_wr + 16'd1;
      end else begin
        if (stat_rd != '1) stat_rd <= stat_rd + 16'd1;
      end
    end
  end
`endif

endmodule
